// File: rtl/npc_seq.sv
// npc_seq: multi-cycle instruction sequencer for the NPC core.
// Owns the PC and steps each instruction through fetch, execute, optional
// memory access and writeback. Every output is a register or is decoded from
// the state register, so no input reaches an output combinationally.
module npc_seq #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_addr,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_inst,
  output logic [31:0] inst,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        dec_rd_wen,
  input  logic        dec_ebreak,
  input  logic [31:0] alu_next_pc,
  output logic        lsu_req_valid,
  output logic        lsu_wen,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  input  logic [31:0] lsu_rdata,
  output logic [31:0] rdata,
  output logic [31:0] pc,
  output logic        rf_wen,
  output logic [31:0] instret,
  output logic        halt,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_IWAIT = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MREQ  = 3'd3;
  localparam logic [2:0] S_MWAIT = 3'd4;
  localparam logic [2:0] S_WB    = 3'd5;
  localparam logic [2:0] S_HALT  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_FETCH = 2'b01;
  localparam logic [1:0] E_MEM   = 2'b10;
  localparam logic [1:0] E_ALIGN = 2'b11;

  // The watchdog counter holds (cycles already spent - 1) in a wait state,
  // so the cycle where it equals this value is the last one allowed.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 32'd1);

  logic [2:0]  state_r;
  logic [2:0]  next_s;
  logic [1:0]  err_code_r;
  logic [1:0]  err_next_s;
  logic [15:0] wdog_r;
  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic [31:0] rdata_r;
  logic [31:0] instret_r;
  logic        store_r;
  logic        wen_ok_r;
  logic        wdog_expire_s;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  assign wdog_expire_s = (wdog_r == TO_LAST);

  // Next-state and error-cause selection.
  always_comb begin
    next_s     = state_r;
    err_next_s = err_code_r;
    case (state_r)
      S_FETCH: begin
        if (ifu_req_ready) next_s = S_IWAIT;
        else               next_s = S_FETCH;
      end
      S_IWAIT: begin
        if (ifu_rsp_valid) begin
          next_s = S_EXEC;
        end else if (wdog_expire_s) begin
          next_s     = S_ERR;
          err_next_s = E_FETCH;
        end else begin
          next_s = S_IWAIT;
        end
      end
      S_EXEC: begin
        if (dec_ebreak)                 next_s = S_HALT;
        else if (dec_load || dec_store) next_s = S_MREQ;
        else                            next_s = S_WB;
      end
      S_MREQ: begin
        if (lsu_req_ready) next_s = S_MWAIT;
        else               next_s = S_MREQ;
      end
      S_MWAIT: begin
        if (lsu_rsp_valid) begin
          next_s = S_WB;
        end else if (wdog_expire_s) begin
          next_s     = S_ERR;
          err_next_s = E_MEM;
        end else begin
          next_s = S_MWAIT;
        end
      end
      S_WB: begin
        if (is_aligned(alu_next_pc)) begin
          next_s = S_FETCH;
        end else begin
          next_s     = S_ERR;
          err_next_s = E_ALIGN;
        end
      end
      S_HALT:  next_s = S_HALT;
      S_ERR:   next_s = S_ERR;
      default: next_s = S_ERR;
    endcase
  end

  // State, error cause and watchdog counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_FETCH;
      err_code_r <= E_NONE;
      wdog_r     <= 16'd0;
    end else begin
      state_r    <= next_s;
      err_code_r <= err_next_s;
      if (state_r == S_IWAIT || state_r == S_MWAIT) wdog_r <= wdog_r + 16'd1;
      else                                          wdog_r <= 16'd0;
    end
  end

  // Datapath registers: PC, latched instruction/load data, retire count and
  // the decoder flags captured in EXEC so outputs never depend on inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r      <= RESET_PC;
      inst_r    <= 32'd0;
      rdata_r   <= 32'd0;
      instret_r <= 32'd0;
      store_r   <= 1'b0;
      wen_ok_r  <= 1'b0;
    end else begin
      if (state_r == S_IWAIT && ifu_rsp_valid) inst_r <= ifu_rsp_inst;
      if (state_r == S_MWAIT && lsu_rsp_valid && !store_r) rdata_r <= lsu_rdata;
      if (state_r == S_WB && is_aligned(alu_next_pc)) begin
        pc_r      <= alu_next_pc;
        instret_r <= instret_r + 32'd1;
      end
      if (state_r == S_EXEC) begin
        store_r  <= dec_store;
        wen_ok_r <= dec_rd_wen & ~dec_store & is_aligned(alu_next_pc);
      end
    end
  end

  assign ifu_req_valid = (state_r == S_FETCH);
  assign ifu_addr      = pc_r;
  assign pc            = pc_r;
  assign inst          = inst_r;
  assign rdata         = rdata_r;
  assign instret       = instret_r;
  assign lsu_req_valid = (state_r == S_MREQ);
  assign lsu_wen       = store_r;
  assign rf_wen        = (state_r == S_WB) & wen_ok_r;
  assign halt          = (state_r == S_HALT);
  assign err           = (state_r == S_ERR);
  assign err_code      = err_code_r;

endmodule

// File: tb/tb_npc_seq.sv
// Self-checking bench for npc_seq: directed scenarios plus randomized
// instruction streams checked against a per-instruction reference model.
module tb_npc_seq;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          TMO    = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_addr, ifu_rsp_inst, inst;
  logic        dec_load, dec_store, dec_rd_wen, dec_ebreak;
  logic [31:0] alu_next_pc;
  logic        lsu_req_valid, lsu_wen, lsu_req_ready, lsu_rsp_valid;
  logic [31:0] lsu_rdata, rdata, pc, instret;
  logic        rf_wen, halt, err;
  logic [1:0]  err_code;

  int n_assert = 0;
  int n_fail   = 0;
  int rf_seen  = 0;

  logic [31:0] exp_pc, exp_instret, exp_rdata;

  npc_seq #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr), .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst),
    .inst(inst), .dec_load(dec_load), .dec_store(dec_store),
    .dec_rd_wen(dec_rd_wen), .dec_ebreak(dec_ebreak), .alu_next_pc(alu_next_pc),
    .lsu_req_valid(lsu_req_valid), .lsu_wen(lsu_wen), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata), .rdata(rdata),
    .pc(pc), .rf_wen(rf_wen), .instret(instret), .halt(halt), .err(err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (rf_wen === 1'b1) rf_seen++;
  endtask

  task automatic clear_inputs();
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_inst = 32'd0;
    dec_load = 1'b0; dec_store = 1'b0; dec_rd_wen = 1'b0; dec_ebreak = 1'b0;
    alu_next_pc = 32'd0; lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0; lsu_rdata = 32'd0;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    clear_inputs();
    #2;
    chk("rst_pc", pc, RST_PC);
    chk("rst_inst", inst, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_flags", {28'd0, rf_wen, halt, err, lsu_req_valid}, 32'd0);
    chk("rst_err_code", {30'd0, err_code}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_fetch_valid", {31'd0, ifu_req_valid}, 32'd1);
    chk("rst_fetch_addr", ifu_addr, RST_PC);
    exp_pc = RST_PC; exp_instret = 32'd0; exp_rdata = 32'd0;
  endtask

  // kind: 0 ALU, 1 load, 2 store, 3 ebreak (with dec_load also set).
  task automatic run_instr(input int kind, input logic rdw, input logic [31:0] npc,
                           input int fw, input int id, input int mw, input int md,
                           input logic [31:0] ld, input logic spur);
    logic [31:0] iw;
    logic        mis;
    int          exp_rf;
    iw = $urandom();
    dec_load = (kind == 1) || (kind == 3);
    dec_store = (kind == 2);
    dec_ebreak = (kind == 3);
    dec_rd_wen = rdw;
    alu_next_pc = npc;
    rf_seen = 0;
    for (int i = 0; i < fw; i++) begin
      chk("fetch_wait_valid", {31'd0, ifu_req_valid}, 32'd1);
      chk("fetch_wait_addr", ifu_addr, exp_pc);
      step();
    end
    chk("fetch_valid", {31'd0, ifu_req_valid}, 32'd1);
    chk("fetch_addr", ifu_addr, exp_pc);
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    for (int i = 0; i < id; i++) begin
      chk("iwait_no_req", {31'd0, ifu_req_valid}, 32'd0);
      step();
    end
    ifu_rsp_valid = 1'b1;
    ifu_rsp_inst = iw;
    step();
    ifu_rsp_valid = 1'b0;
    chk("exec_inst", inst, iw);
    chk("exec_no_req", {30'd0, ifu_req_valid, lsu_req_valid}, 32'd0);
    if (spur) begin
      ifu_rsp_valid = 1'b1; ifu_rsp_inst = ~iw;
      lsu_rsp_valid = 1'b1; lsu_rdata = ~ld;
    end
    step();
    ifu_rsp_valid = 1'b0; lsu_rsp_valid = 1'b0;
    chk("inst_hold", inst, iw);
    if (kind == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("halt", {31'd0, halt}, 32'd1);
        chk("halt_pc", pc, exp_pc);
        chk("halt_instret", instret, exp_instret);
        chk("halt_no_req", {29'd0, ifu_req_valid, lsu_req_valid, rf_wen}, 32'd0);
        ifu_req_ready = 1'b1;
        step();
      end
      ifu_req_ready = 1'b0;
      chk("halt_rf_pulses", rf_seen, 32'd0);
      return;
    end
    if (kind == 1 || kind == 2) begin
      for (int i = 0; i < mw; i++) begin
        chk("mreq_wait_valid", {31'd0, lsu_req_valid}, 32'd1);
        chk("mreq_wait_wen", {31'd0, lsu_wen}, (kind == 2) ? 32'd1 : 32'd0);
        step();
      end
      chk("mreq_valid", {31'd0, lsu_req_valid}, 32'd1);
      chk("mreq_wen", {31'd0, lsu_wen}, (kind == 2) ? 32'd1 : 32'd0);
      lsu_req_ready = 1'b1;
      step();
      lsu_req_ready = 1'b0;
      for (int i = 0; i < md; i++) begin
        chk("mwait_no_req", {31'd0, lsu_req_valid}, 32'd0);
        step();
      end
      lsu_rsp_valid = 1'b1;
      lsu_rdata = ld;
      step();
      lsu_rsp_valid = 1'b0;
      if (kind == 1) exp_rdata = ld;
    end
    // Now in the writeback cycle.
    chk("wb_rdata", rdata, exp_rdata);
    chk("wb_no_req", {30'd0, ifu_req_valid, lsu_req_valid}, 32'd0);
    step();
    mis = (npc[1:0] != 2'b00);
    exp_rf = (rdw && kind != 2 && !mis) ? 1 : 0;
    chk("rf_pulses", rf_seen, exp_rf);
    if (mis) begin
      chk("mis_err", {31'd0, err}, 32'd1);
      chk("mis_code", {30'd0, err_code}, 32'd3);
      chk("mis_no_req", {31'd0, ifu_req_valid}, 32'd0);
    end else begin
      exp_pc = npc;
      exp_instret = exp_instret + 32'd1;
      chk("next_fetch", {31'd0, ifu_req_valid}, 32'd1);
      chk("next_addr", ifu_addr, exp_pc);
      chk("no_err", {31'd0, err}, 32'd0);
    end
    chk("pc", pc, exp_pc);
    chk("instret", instret, exp_instret);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] npc;
    clear_inputs();
    #1;
    do_reset();

    // addi, zero wait.
    run_instr(0, 1'b1, 32'h8000_0004, 0, 0, 0, 0, 32'd0, 1'b0);
    // lw with request backpressure and delayed response.
    run_instr(1, 1'b1, 32'h8000_0008, 0, 0, 3, 2, 32'hDEAD_BEEF, 1'b0);
    // sw with rd_wen set: no register write, rdata unchanged.
    run_instr(2, 1'b1, 32'h8000_000C, 0, 0, 0, 0, 32'h1234_5678, 1'b1);

    // Random instruction stream.
    for (int n = 0; n < 40; n++) begin
      r = $urandom();
      if ($urandom_range(0, 3) == 0) npc = {r[31:2], 2'b00};
      else                           npc = exp_pc + 32'd4;
      run_instr(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), npc,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                $urandom(), 1'($urandom_range(0, 1)));
    end

    // Misaligned next PC.
    run_instr(0, 1'b1, exp_pc + 32'd2, 0, 0, 0, 0, 32'd0, 1'b0);

    // Reset mid-fetch; late response must be ignored.
    do_reset();
    ifu_req_ready = 1'b1;
    step();
    do_reset();
    ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'hCAFE_F00D;
    step();
    ifu_rsp_valid = 1'b0;
    chk("late_rsp_fetch", {31'd0, ifu_req_valid}, 32'd1);
    chk("late_rsp_inst", inst, 32'd0);

    // ebreak (with load also decoded) halts.
    run_instr(3, 1'b1, 32'h8000_0004, 1, 1, 0, 0, 32'd0, 1'b0);

    // Fetch timeout.
    do_reset();
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      chk("ito_no_err", {31'd0, err}, 32'd0);
      step();
    end
    chk("ito_err", {31'd0, err}, 32'd1);
    chk("ito_code", {30'd0, err_code}, 32'd1);
    chk("ito_no_req", {30'd0, ifu_req_valid, lsu_req_valid}, 32'd0);

    // Memory timeout on a load.
    do_reset();
    dec_load = 1'b1;
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b1;
    step();
    ifu_rsp_valid = 1'b0;
    step();
    chk("mto_mreq", {31'd0, lsu_req_valid}, 32'd1);
    lsu_req_ready = 1'b1;
    step();
    lsu_req_ready = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      chk("mto_no_err", {31'd0, err}, 32'd0);
      step();
    end
    chk("mto_err", {31'd0, err}, 32'd1);
    chk("mto_code", {30'd0, err_code}, 32'd2);
    chk("mto_no_req", {30'd0, ifu_req_valid, lsu_req_valid}, 32'd0);
    chk("mto_instret", instret, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/npc_seq.md
# npc_seq

Multi-cycle instruction sequencer for the NPC core. It owns the PC and steps each instruction through fetch, execute, optional memory access and writeback around the combinational ALU. It drives valid/ready handshakes to the instruction-fetch and load/store memory ports and latches the instruction word and load data that feed the decoder and the ALU `rdata` input. It also produces register-file write strobes, retire counting, halt on `ebreak` and a watchdog error.

## Interface
- `RESET_PC`, 32'h8000_0000: PC value loaded on reset.
- `TIMEOUT`, 1024: maximum cycles spent in a response-wait state before error; 1 to 65535.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `ifu_req_valid` out 1: fetch request.
- `ifu_req_ready` in 1: fetch port accepts the request.
- `ifu_addr` out 32: fetch address, always equal to `pc`.
- `ifu_rsp_valid` in 1: instruction data valid.
- `ifu_rsp_inst` in 32: instruction data.
- `inst` out 32: latched instruction to the decoder.
- `dec_load` in 1: decoded load (ALU op bit 6).
- `dec_store` in 1: decoded store.
- `dec_rd_wen` in 1: instruction writes rd.
- `dec_ebreak` in 1: decoded ebreak.
- `alu_next_pc` in 32: next PC from the ALU.
- `lsu_req_valid` out 1: memory request.
- `lsu_wen` out 1: 1 = store, 0 = load; valid with `lsu_req_valid`.
- `lsu_req_ready` in 1: memory port accepts the request.
- `lsu_rsp_valid` in 1: memory response.
- `lsu_rdata` in 32: load data.
- `rdata` out 32: latched load data to the ALU.
- `pc` out 32: current PC to the ALU.
- `rf_wen` out 1: register-file write strobe.
- `instret` out 32: retired-instruction count.
- `halt` out 1: ebreak reached.
- `err` out 1: error stop.
- `err_code` out 2: 01 = fetch timeout, 10 = memory timeout, 11 = misaligned next PC.

## Operation
- States: FETCH, IWAIT, EXEC, MREQ, MWAIT, WB, HALT, ERR.
- **FETCH**
  - `ifu_req_valid`=1.
  - When `ifu_req_ready`=1, go to IWAIT.
  - `ifu_addr` stays stable while waiting.
  - No timeout in this state.
- **IWAIT**
  - When `ifu_rsp_valid`=1, latch `ifu_rsp_inst` into `inst` and go to EXEC.
  - The response is accepted only in this state. Responses in any other state are ignored.
- **EXEC** (one cycle; decoder and ALU settle), checked in this priority:
  - `dec_ebreak`: go to HALT.
  - `dec_load` or `dec_store`: go to MREQ.
  - Otherwise: go to WB.
- **MREQ**
  - `lsu_req_valid`=1 and `lsu_wen`=`dec_store`.
  - When `lsu_req_ready`=1, go to MWAIT.
- **MWAIT**
  - When `lsu_rsp_valid`=1, go to WB.
  - On a load, latch `lsu_rdata` into `rdata`. On a store, `rdata` is unchanged.
- **WB** (one cycle):
  - If `alu_next_pc[1:0]`≠0: go to ERR with code 11. No write, no retire, `pc` unchanged.
  - Otherwise:
    - `rf_wen`=`dec_rd_wen` and not store.
    - `pc` loads `alu_next_pc`.
    - `instret` increments, wrapping 32'hFFFF_FFFF to 0.
    - Go to FETCH.
- **HALT**
  - `halt`=1 and the sequencer stays here.
  - The ebreak is not retired and `pc` holds its address.
- **ERR**
  - `err`=1 and `err_code` holds the cause.
  - The sequencer stays here and all requests are deasserted.
- **Watchdog**
  - A 16-bit counter clears on entry to IWAIT or MWAIT and increments each cycle in those states.
  - When it reaches `TIMEOUT` while the response is still absent, go to ERR with code 01 or 10.
  - A response in the same cycle the counter reaches `TIMEOUT` wins: proceed normally.
- `inst` and `rdata` hold their values until overwritten.
- Decoder inputs are sampled only in EXEC and WB. They must stay stable from EXEC through WB because `inst` is stable.

## Timing
- **Reset** (asynchronous on `rst_n`=0, any state). Outputs take these values immediately:
  - state FETCH, `pc`=`RESET_PC`.
  - `inst`=0, `rdata`=0, `instret`=0.
  - `rf_wen`=0, `halt`=0, `err`=0, `err_code`=0, `lsu_req_valid`=0.
  - `ifu_req_valid`=1 as soon as `rst_n` releases.
- Reset during IWAIT or MWAIT abandons the transaction. A late response arriving in FETCH is ignored.
- All outputs are registered or decoded from state only; there is no combinational input-to-output path.
- Minimum latency with zero-wait ports (ready=1, response one cycle after accept):
  - ALU/jump instruction: 4 cycles (FETCH, IWAIT, EXEC, WB).
  - Load/store: 6 cycles.
- `rf_wen` is a single-cycle pulse in WB. The register file captures on that edge, with `rdata` already valid for loads.

## Test plan
- **Reset and first fetch:** reset, then release → `ifu_req_valid`=1 and `ifu_addr`=0x8000_0000 in the first cycle; `instret`=0.
- **addi, zero wait:** `dec_rd_wen`=1, `alu_next_pc`=0x8000_0004 → exactly 4 cycles per instruction, one `rf_wen` pulse, `pc`=0x8000_0004, `instret`=1.
- **lw with backpressure:** `lsu_req_ready` low for 3 cycles, response `lsu_rdata`=0xDEAD_BEEF after 2 more cycles → `lsu_wen`=0, `rdata`=0xDEAD_BEEF before the `rf_wen` pulse; total 11 cycles.
- **Store:** `dec_store`=1 and `dec_rd_wen`=1 → `lsu_wen`=1 and `rf_wen` stays 0.
- **ebreak:** `dec_ebreak`=1 → `halt`=1 one cycle after EXEC, `pc` unchanged, `instret` unchanged, no further requests.
- **Timeout and misalignment:**
  - `TIMEOUT`=8, fetch response never arrives → `err`=1 with `err_code`=01 after exactly 8 IWAIT cycles.
  - Separately, `alu_next_pc`=0x8000_0002 → `err_code`=11 with no retire.
